// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between EX stage and the multiply/divide unit
interface muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues ops and flushes, observes status and HI/LO.
  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  // Unit side: owns HI/LO and the busy/done status.
  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit_param.sv
// rtl/muldiv_unit_param.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module muldiv_unit_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  // The counter only ever holds LAT-1, so it needs to count up to MAX_LAT-1.
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int RW      = 2 * WIDTH;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [RW-1:0]    res_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic             accept, complete, write_hi, write_lo, abort;

  logic [WIDTH-1:0] a, b;
  assign a = bus.a;
  assign b = bus.b;

  // ------------------------------------------------------------------
  // Arithmetic: the whole result is formed at launch and parked in res_q;
  // the counter only models the latency the pipeline must observe.
  // ------------------------------------------------------------------
  logic [RW-1:0]    acc, a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  logic [WIDTH-1:0] div_b, a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [RW-1:0]    res_calc;
  logic             is_div;

  assign acc    = {hi_q, lo_q};
  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  // Two's-complement products truncated to 2W bits equal the signed product.
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Keep the divider free of a zero divisor; the zero case is overridden below.
  assign div_b  = (b == '0) ? WIDTH'(1) : b;
  // Magnitudes: negating the most-negative value yields 2^(W-1) as unsigned,
  // which makes most-negative / -1 fall out as most-negative with remainder 0.
  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = (b[WIDTH-1] ? -b : b) | {{(WIDTH-1){1'b0}}, (b == '0)};
  assign q_mag  = a_mag / b_mag;
  assign r_mag  = a_mag % b_mag;
  assign q_s    = (a[WIDTH-1] ^ b[WIDTH-1]) ? -q_mag : q_mag;
  assign r_s    = a[WIDTH-1] ? -r_mag : r_mag;
  assign q_u    = a / div_b;
  assign r_u    = a % div_b;

  assign is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);

  // Select the pending {hi,lo} value for the op being launched.
  always_comb begin
    res_calc = '0;
    case (bus.op)
      OP_MULT:  res_calc = prod_s;
      OP_MULTU: res_calc = prod_u;
      OP_DIV:   res_calc = (b == '0) ? {a, {WIDTH{1'b1}}} : {r_s, q_s};
      OP_DIVU:  res_calc = (b == '0) ? {a, {WIDTH{1'b1}}} : {r_u, q_u};
      OP_MADD:  res_calc = acc + prod_s;
      OP_MADDU: res_calc = acc + prod_u;
      OP_MSUB:  res_calc = acc - prod_s;
      OP_MSUBU: res_calc = acc - prod_u;
      default:  res_calc = '0;
    endcase
  end

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle actions; flush overrides launch, MT* and completion.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    write_hi = 1'b0;
    write_lo = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.flush) begin
          if (bus.start && (bus.op <= OP_MSUBU)) begin
            accept  = 1'b1;
            state_d = RUN;
          end
          write_hi = (bus.op == OP_MTHI);
          write_lo = (bus.op == OP_MTLO);
        end
      end
      RUN: begin
        if (bus.flush) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------

  // Latency counter and parked result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      res_q <= '0;
    end else if (accept) begin
      cnt_q <= is_div ? DIV_CNT : MUL_CNT;
      res_q <= res_calc;
    end else if (abort) begin
      cnt_q <= '0;
    end else if ((state_q == RUN) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Architectural HI/LO: written by a completing op or by MTHI/MTLO in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (complete) begin
      hi_q <= res_q[RW-1:WIDTH];
      lo_q <= res_q[WIDTH-1:0];
    end else begin
      if (write_hi) hi_q <= a;
      if (write_lo) lo_q <= a;
    end
  end

  // Done marks the edge HI/LO took a result; it can only follow a RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= complete;
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit_param.sv
// tb/tb_muldiv_unit_param.sv - self-checking bench for muldiv_unit_param
module tb_muldiv_unit_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) m ();
  muldiv_if #(.WIDTH(32)) f ();

  muldiv_unit_param #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .bus(m)
  );
  muldiv_unit_param #(.WIDTH(32), .MUL_LAT(1), .DIV_LAT(3)) dut_fast (
    .clk(clk), .reset(reset), .bus(f)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] mdl;   // expected {hi,lo} of the main unit

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
    int sa, sb;
    longint sp;
    logic [63:0] up;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    sp = longint'(sa) * longint'(sb);
    up = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0: return 64'(sp);
      4'd1: return up;
      4'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      4'd4: return acc + 64'(sp);
      4'd5: return acc + up;
      4'd6: return acc - 64'(sp);
      4'd7: return acc - up;
      default: return acc;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] op, input int mul_lat, input int div_lat);
    return (op == 4'd2 || op == 4'd3) ? div_lat : mul_lat;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  // Launch one md op on the main unit and check latency, done pulse and result.
  task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int n;
    @(negedge clk);
    m.start = 1'b1; m.op = op; m.a = a; m.b = b;
    @(negedge clk);
    m.start = 1'b0; m.op = 4'hF;
    n = 0;
    while (m.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({name, " busy_cycles"}, 64'(n), 64'(lat_of(op, 5, 10)));
    chk({name, " done"}, 64'(m.done), 64'd1);
    chk({name, " hi_lo"}, {m.hi, m.lo}, exp);
    @(negedge clk);
    chk({name, " done_once"}, 64'(m.done), 64'd0);
  endtask

  task automatic run_fast(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
    int n;
    @(negedge clk);
    f.start = 1'b1; f.op = op; f.a = a; f.b = b;
    @(negedge clk);
    f.start = 1'b0; f.op = 4'hF;
    n = 0;
    while (f.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({name, " busy_cycles"}, 64'(n), 64'(lat_of(op, 1, 3)));
    chk({name, " done"}, 64'(f.done), 64'd1);
    chk({name, " hi_lo"}, {f.hi, f.lo}, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic saw;
    logic [3:0] rop;
    logic [31:0] ra, rb;
    logic [63:0] exp;

    tbl[0] = '{4'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1] = '{4'd1, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
    tbl[2] = '{4'd4, 32'd1,         32'd1,         32'h0000_0001, 32'hFFFF_FFFF};
    tbl[3] = '{4'd7, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 32'h0000_0000};
    tbl[4] = '{4'd6, 32'd1,         32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
    tbl[5] = '{4'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[6] = '{4'd3, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF};
    tbl[7] = '{4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[8] = '{4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0001};
    tbl[9] = '{4'd2, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF};

    m.start = 1'b0; m.op = 4'hF; m.a = '0; m.b = '0; m.flush = 1'b0;
    f.start = 1'b0; f.op = 4'hF; f.a = '0; f.b = '0; f.flush = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("reset busy", 64'(m.busy), 64'd0);
    chk("reset done", 64'(m.done), 64'd0);
    chk("reset hi_lo", {m.hi, m.lo}, 64'd0);
    mdl = '0;

    // Directed vectors (results depend on the previous entry's HI/LO).
    for (int i = 0; i < 10; i++) begin
      run_md($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo});
      mdl = {tbl[i].hi, tbl[i].lo};
    end

    // Flush on the 4th busy cycle of a DIV.
    @(negedge clk);
    m.start = 1'b1; m.op = 4'd2; m.a = 32'd100; m.b = 32'd7;
    @(negedge clk);
    m.start = 1'b0; m.op = 4'hF;
    repeat (3) @(negedge clk);
    chk("flush4 busy_before", 64'(m.busy), 64'd1);
    m.flush = 1'b1;
    @(negedge clk);
    m.flush = 1'b0;
    chk("flush4 busy_after", 64'(m.busy), 64'd0);
    saw = m.done;
    repeat (12) begin
      @(negedge clk);
      saw = saw | m.done;
    end
    chk("flush4 no_done", 64'(saw), 64'd0);
    chk("flush4 hi_lo", {m.hi, m.lo}, mdl);

    // Flush in the same cycle as completion of a MULT.
    @(negedge clk);
    m.start = 1'b1; m.op = 4'd0; m.a = 32'd3; m.b = 32'd3;
    @(negedge clk);
    m.start = 1'b0; m.op = 4'hF;
    repeat (4) @(negedge clk);
    chk("flush_last busy_before", 64'(m.busy), 64'd1);
    m.flush = 1'b1;
    @(negedge clk);
    m.flush = 1'b0;
    chk("flush_last busy_after", 64'(m.busy), 64'd0);
    chk("flush_last no_done", 64'(m.done), 64'd0);
    chk("flush_last hi_lo", {m.hi, m.lo}, mdl);
    @(negedge clk);
    chk("flush_last no_done_late", 64'(m.done), 64'd0);

    // Second start and MTHI while a MULT runs are ignored.
    ra = $urandom; rb = $urandom;
    exp = ref_md(4'd0, ra, rb, mdl);
    n = 0;
    @(negedge clk);
    m.start = 1'b1; m.op = 4'd0; m.a = ra; m.b = rb;
    @(negedge clk);
    n += int'(m.busy);
    m.start = 1'b1; m.op = 4'd3; m.a = 32'd9; m.b = 32'd2;
    @(negedge clk);
    n += int'(m.busy);
    m.start = 1'b0; m.op = 4'd8; m.a = 32'd5;
    @(negedge clk);
    n += int'(m.busy);
    m.op = 4'hF;
    @(negedge clk);
    while (m.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("overlap busy_cycles", 64'(n), 64'd5);
    chk("overlap done", 64'(m.done), 64'd1);
    chk("overlap hi_lo", {m.hi, m.lo}, exp);
    mdl = exp;
    @(negedge clk);
    chk("overlap busy_stays_low", 64'(m.busy), 64'd0);

    // MTHI / MTLO in IDLE.
    m.op = 4'd8; m.a = 32'd5;
    @(negedge clk);
    m.op = 4'hF;
    mdl[63:32] = 32'd5;
    chk("mthi hi_lo", {m.hi, m.lo}, mdl);
    chk("mthi busy", 64'(m.busy), 64'd0);
    chk("mthi done", 64'(m.done), 64'd0);
    m.op = 4'd9; m.a = 32'h1234_5678;
    @(negedge clk);
    m.op = 4'hF;
    mdl[31:0] = 32'h1234_5678;
    chk("mtlo hi_lo", {m.hi, m.lo}, mdl);

    // Flush blocks start and MTHI in IDLE.
    m.start = 1'b1; m.op = 4'd0; m.a = 32'd2; m.b = 32'd2; m.flush = 1'b1;
    @(negedge clk);
    m.start = 1'b0; m.flush = 1'b0; m.op = 4'hF;
    chk("flush_start busy", 64'(m.busy), 64'd0);
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw = saw | m.done | m.busy;
    end
    chk("flush_start quiet", 64'(saw), 64'd0);
    m.op = 4'd8; m.a = 32'hDEAD_BEEF; m.flush = 1'b1;
    @(negedge clk);
    m.op = 4'hF; m.flush = 1'b0;
    chk("flush_mthi hi_lo", {m.hi, m.lo}, mdl);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 9));
      ra = pick();
      rb = pick();
      if (rop < 4'd8) begin
        exp = ref_md(rop, ra, rb, mdl);
        run_md($sformatf("rnd%0d op%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb, exp);
        mdl = exp;
      end else begin
        @(negedge clk);
        m.op = rop; m.a = ra;
        @(negedge clk);
        m.op = 4'hF;
        if (rop == 4'd8) mdl[63:32] = ra;
        else             mdl[31:0]  = ra;
        chk($sformatf("rnd%0d mt op%0d", i, rop), {m.hi, m.lo}, mdl);
      end
    end

    // Reset in the middle of a DIV.
    @(negedge clk);
    m.start = 1'b1; m.op = 4'd2; m.a = 32'd50; m.b = 32'd3;
    @(negedge clk);
    m.start = 1'b0; m.op = 4'hF;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid busy", 64'(m.busy), 64'd0);
    chk("reset_mid done", 64'(m.done), 64'd0);
    chk("reset_mid hi_lo", {m.hi, m.lo}, 64'd0);
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw = saw | m.done;
    end
    chk("reset_mid no_done", 64'(saw), 64'd0);

    // Short-latency instance.
    run_fast("fast mult", 4'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    run_fast("fast div", 4'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
